// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: OUT/IN/EDGE(W1C)/IRQ_EN registers, 2-flop input sync, level irq.
// Optional per-pin debounce compiled in with `define GPIO_DEBOUNCE_EN (IN latency becomes 2 + DEBOUNCE_CYCLES).
module gpio_mmio #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_port_in,
    output logic [WIDTH-1:0] gpio_port_out,
    output logic             irq
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] in_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] wmask;
    logic             wr_out;
    logic             wr_edge;
    logic             wr_irq_en;
    logic             unused_bits;

    assign wmask       = wdata[WIDTH-1:0];
    assign wr_out      = we && (addr[3:2] == 2'd0);
    assign wr_edge     = we && (addr[3:2] == 2'd2);
    assign wr_irq_en   = we && (addr[3:2] == 2'd3);
    assign unused_bits = ^{addr[1:0], wdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_port_in;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       cnt_q    [WIDTH];
    logic [7:0]       cnt_next [WIDTH];
    logic [WIDTH-1:0] in_reg;

    // A pin's counter only runs while the synchronized value disagrees with IN;
    // the DEBOUNCE_CYCLES-th consecutive disagreeing sample commits the new value.
    always_comb begin
        in_next = in_reg;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != in_reg[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    in_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_reg <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            in_reg <= in_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end

    assign in_q = in_reg;
`else
    // Without debounce the second synchronizer stage is IN itself.
    assign in_next = sync1;
    assign in_q    = sync2;
`endif

    // Edges are detected on the value IN is about to take, so EDGE and IN update together.
    assign rise      = in_next & ~in_q;
    assign edge_next = (edge_q & ~(wr_edge ? wmask : '0)) | rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= '0;
            irq_en_q <= '0;
            edge_q   <= '0;
        end else begin
            if (wr_out) begin
                out_q <= wmask;
            end
            if (wr_irq_en) begin
                irq_en_q <= wmask;
            end
            edge_q <= edge_next;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            2'd0:    rdata[WIDTH-1:0] = out_q;
            2'd1:    rdata[WIDTH-1:0] = in_q;
            2'd2:    rdata[WIDTH-1:0] = edge_q;
            default: rdata[WIDTH-1:0] = irq_en_q;
        endcase
    end

    assign gpio_port_out = out_q;
    assign irq           = |(edge_q & irq_en_q);

endmodule

// File: doc/gpio_mmio.md
GPIO_MMIO -- requirements
Module: gpio_mmio

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of GPIO pins in each direction (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: number of stable synchronized samples required before IN updates (2..255); used only when GPIO_DEBOUNCE_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  input  4  byte offset of the register (bits [1:0] ignored).
REQ-006 SHALL have port we  input  1  write strobe from the core's data-memory stage.
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port rdata  output  32  read data.
REQ-009 SHALL have port gpio_port_in  input  WIDTH  asynchronous external pins.
REQ-010 SHALL have port gpio_port_out  output  WIDTH  driven pins.
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 SHALL decode the register map as 0x0 OUT (RW), 0x4 IN (RO), 0x8 EDGE (RW1C), 0xC IRQ_EN (RW).
REQ-013 SHALL drive rdata combinationally from current register state (zero-wait read, so the single-cycle core sees it in the same cycle); unused upper bits read 0; the 0x0–0xC map is fully decoded, so there are no unmapped offsets.
REQ-014 SHALL update OUT/IRQ_EN from wdata[WIDTH-1:0] on the rising edge where we=1; gpio_port_out equals OUT with zero added latency.
REQ-015 SHALL ignore writes to IN.
REQ-016 SHALL pass each gpio_port_in bit through a 2-flop synchronizer; IN reflects a pin change exactly 2 rising edges after it is sampled (debounce off).
REQ-017 SHALL set EDGE[i] on the cycle IN[i] transitions 0->1 (sticky until cleared).
REQ-018 SHALL clear EDGE[i] on a write to 0x8 with wdata[i]=1; wdata[i]=0 leaves the bit unchanged.
REQ-019 SHALL give set priority: a new rising edge in the same cycle as W1C of that bit leaves EDGE[i]=1.
REQ-020 SHALL drive irq = |(EDGE & IRQ_EN), combinational from registers, no additional latency.
REQ-021 SHALL not generate edges for 1->0 transitions.

Reset
REQ-022 SHALL, while rst=0, asynchronously force OUT, IN, EDGE, IRQ_EN, both synchronizer stages and all debounce counters to 0; gpio_port_out=0, irq=0, rdata reflects zeros.
REQ-023 SHALL, on reset assertion mid-operation (e.g. during an in-progress debounce count), discard pending state; no edge is reported for a pin already high at deassertion until IN first rises from 0.
REQ-024 SHALL leave the first post-reset IN update governed by normal synchronizer/debounce latency.

Configuration
REQ-025 SHALL use macro GPIO_DEBOUNCE_EN to compile per-bit debounce in or out.
REQ-026 SHALL, with GPIO_DEBOUNCE_EN defined, update IN[i] only after the synchronized bit has differed from IN[i] for DEBOUNCE_CYCLES consecutive cycles; any return to the IN value resets that bit's counter to 0; total pin-to-IN latency = 2 + DEBOUNCE_CYCLES cycles.
REQ-027 SHALL, without GPIO_DEBOUNCE_EN, instantiate no counters and load IN directly from the synchronizer output (latency 2, REQ-016).

Verification
REQ-028 SHALL cover: reset released, write 0x0=0x000000A5 -> gpio_port_out=0xA5 next edge, read 0x0 returns 0x000000A5.
REQ-029 SHALL cover: gpio_port_in 0x00->0x02, no debounce -> read 0x4=0x02 after 2 edges, EDGE=0x02; with IRQ_EN=0x02, irq=1 same cycle.
REQ-030 SHALL cover: EDGE=0x02, write 0x8=0x02 -> EDGE=0x00, irq=0; write 0x8=0x00 -> EDGE unchanged.
REQ-031 SHALL cover: pin1 rises so its edge lands on the same cycle as W1C of bit 1 -> EDGE[1]=1 after the edge.
REQ-032 SHALL cover: GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, pin0 glitch high 3 cycles -> IN[0] stays 0; held 4 cycles -> IN[0]=1 at cycle 6 after change.
REQ-033 SHALL cover: rst asserted mid-debounce with OUT=0xFF -> gpio_port_out=0x00 and irq=0 immediately (asynchronous), all reads return 0.
